pipo_load_arbiter: RTL and testbench

Shares one WIDTH-bit parallel-in/parallel-out holding register between NREQ requesters. A round-robin arbiter picks one requester, loads its parallel word into the register and holds the value for a minimum number of cycles before the next load. It sits between the PIPO datapath register and the blocks that write it, and reports ownership and validity of the held word.

---
 rtl/pipo_load_arbiter.sv | 85 ++++++++
 tb/tb_pipo_load_arbiter.sv | 132 +++++++++++++
 2 files changed

// File: rtl/pipo_load_arbiter.sv
// pipo_load_arbiter: round-robin loader of a shared PIPO register with minimum hold time.
// Define PIPO_ARB_FIXED_PRI_EN for fixed lowest-index-wins priority (no rr pointer).
module pipo_load_arbiter #(
  parameter int WIDTH       = 4,
  parameter int NREQ        = 4,
  parameter int HOLD_CYCLES = 2,
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1,
  localparam int CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] din,
  output logic [NREQ-1:0]       gnt,
  output logic [WIDTH-1:0]      po,
  output logic                  po_valid,
  output logic [IW-1:0]         po_owner
);
  typedef enum logic {IDLE, HOLD} state_e;
  state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [WIDTH-1:0] po_q, po_d;
  logic valid_q, valid_d;
  logic [IW-1:0] owner_q, owner_d, win;
  logic arb, load;
`ifndef PIPO_ARB_FIXED_PRI_EN
  logic [IW-1:0] ptr_q, ptr_d;
  int j;
`endif
  // Scan downward so the lowest offset from the start point wins last.
  always_comb begin
    win = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
`ifdef PIPO_ARB_FIXED_PRI_EN
      if (req[k]) win = IW'(k);
`else
      j = int'(ptr_q) + k;
      j = (j >= NREQ) ? j - NREQ : j;
      if (req[j]) win = IW'(j);
`endif
    end
  end
  assign arb  = (state_q == IDLE) || (cnt_q == '0);
  assign load = arb && (|req) && !clr;
  always_comb begin
    state_d = clr ? IDLE : load ? HOLD : arb ? IDLE : HOLD;
    cnt_d   = (clr || (arb && !load)) ? '0 : load ? CW'(HOLD_CYCLES - 1) : cnt_q - 1'b1;
    gnt_d   = load ? NREQ'(1) << win : '0;
    po_d    = clr ? '0 : load ? din[win*WIDTH +: WIDTH] : po_q;
    valid_d = clr ? 1'b0 : load ? 1'b1 : valid_q;
    owner_d = load ? win : owner_q;
`ifndef PIPO_ARB_FIXED_PRI_EN
    ptr_d   = !load ? ptr_q : (win == IW'(NREQ - 1)) ? '0 : win + 1'b1;
`endif
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      gnt_q   <= '0;
      po_q    <= '0;
      valid_q <= 1'b0;
      owner_q <= '0;
`ifndef PIPO_ARB_FIXED_PRI_EN
      ptr_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      po_q    <= po_d;
      valid_q <= valid_d;
      owner_q <= owner_d;
`ifndef PIPO_ARB_FIXED_PRI_EN
      ptr_q   <= ptr_d;
`endif
    end
  end
  assign gnt      = gnt_q;
  assign po       = po_q;
  assign po_valid = valid_q;
  assign po_owner = owner_q;
endmodule

// File: tb/tb_pipo_load_arbiter.sv
// tb_pipo_load_arbiter: random and directed checks against a served-order/earliest-load-time model.
module tb_pipo_load_arbiter;
  localparam int W = 4, N = 4, H = 2;
  logic clk = 0, rst = 0, clr = 0;
  logic [N-1:0] req = '0;
  logic [N*W-1:0] din = '0;
  logic [N-1:0] gnt;
  logic [W-1:0] po;
  logic po_valid;
  logic [1:0] po_owner;
  int n_tests = 0, n_fail = 0, cyc;
  logic [W-1:0] m_po;
  logic m_valid;
  logic [1:0] m_owner;
  logic [N-1:0] m_gnt;
  int m_last, m_next_ok;
  pipo_load_arbiter #(.WIDTH(W), .NREQ(N), .HOLD_CYCLES(H)) dut (
    .clk(clk), .rst(rst), .clr(clr), .req(req), .din(din),
    .gnt(gnt), .po(po), .po_valid(po_valid), .po_owner(po_owner));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask
  function automatic int pick();
`ifdef PIPO_ARB_FIXED_PRI_EN
    for (int i = 0; i < N; i++) if (req[i]) return i;
`else
    for (int k = 1; k <= N; k++) if (req[(m_last + k) % N]) return (m_last + k) % N;
`endif
    return -1;
  endfunction
  task automatic model_reset();
    m_po = '0; m_valid = 0; m_owner = '0; m_gnt = '0;
    m_last = N - 1; m_next_ok = 0; cyc = 0;
  endtask
  task automatic step();
    int w;
    @(posedge clk);
    m_gnt = '0;
    if (clr) begin
      m_po = '0; m_valid = 0; m_next_ok = cyc + 1;
    end else if (cyc >= m_next_ok && req != '0) begin
      w = pick();
      m_po = din[w*W +: W]; m_valid = 1; m_owner = 2'(w);
      m_gnt = N'(1) << w; m_last = w; m_next_ok = cyc + H;
    end
    #1;
    chk("po", 32'(po), 32'(m_po));
    chk("po_valid", 32'(po_valid), 32'(m_valid));
    chk("po_owner", 32'(po_owner), 32'(m_owner));
    chk("gnt", 32'(gnt), 32'(m_gnt));
    cyc++;
    @(negedge clk);
  endtask
  task automatic async_reset();
    #2 rst = 0;
    #1;
    chk("arst_po", 32'(po), 0);
    chk("arst_valid", 32'(po_valid), 0);
    chk("arst_gnt", 32'(gnt), 0);
    model_reset();
    @(negedge clk) rst = 1;
  endtask
  initial begin
    model_reset();
    req = 4'b1111;
    din = {4'hD, 4'hF, 4'h5, 4'hA};
    repeat (3) @(negedge clk);
    chk("rst_po", 32'(po), 0);
    chk("rst_valid", 32'(po_valid), 0);
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_owner", 32'(po_owner), 0);
    rst = 1;
    step();
    chk("first_gnt", 32'(gnt), 32'b0001);
    req = '0;
    repeat (3) step();
    req = 4'b0010; din[7:4] = 4'hA;
    step();
    chk("single_po", 32'(po), 32'hA);
    chk("single_owner", 32'(po_owner), 1);
    chk("single_gnt", 32'(gnt), 32'b0010);
    req = '0; din[7:4] = 4'h5;
    step();
    chk("single_gnt_drop", 32'(gnt), 0);
    chk("single_po_hold", 32'(po), 32'hA);
    req = 4'b1111; din = {4'hD, 4'hF, 4'h5, 4'hA};
    step();
    async_reset();
    step();
    chk("rr_first_owner", 32'(po_owner), 0);
    for (int i = 0; i < 9; i++) step();
    for (int i = 0; i < 20 && !(m_gnt[2] && gnt[2]); i++) step();
    chk("clr_pre_owner", 32'(po_owner), 2);
    clr = 1;
    step();
    chk("clr_po", 32'(po), 0);
    chk("clr_valid", 32'(po_valid), 0);
    chk("clr_owner", 32'(po_owner), 2);
    clr = 0;
    step();
`ifdef PIPO_ARB_FIXED_PRI_EN
    chk("clr_next_gnt", 32'(gnt), 32'b0001);
`else
    chk("clr_next_gnt", 32'(gnt), 32'b1000);
`endif
    async_reset();
    req = 4'b0101;
    step();
    chk("arst_first_gnt", 32'(gnt), 32'b0001);
    req = 4'b1010;
    for (int i = 0; i < 8; i++) begin
      step();
`ifdef PIPO_ARB_FIXED_PRI_EN
      chk("fixed_no_req3", 32'(gnt[3]), 0);
`endif
    end
    for (int i = 0; i < 400; i++) begin
      req = N'($urandom);
      din = (N*W)'($urandom);
      clr = ($urandom_range(15) == 0);
      step();
    end
    clr = 0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
